// File: rtl/updown_sweep_ctrl_if.sv
// Host/counter-side signal bundle for updown_sweep_ctrl.
// Optional input hold is present only when UPDOWN_SWEEP_HOLD_EN is defined.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4
);
  logic                start;
  logic                abort;
  logic [WIDTH-1:0]    lo;
  logic [WIDTH-1:0]    hi;
  logic [REPEAT_W-1:0] repeats;
  logic                step_en;
  logic [WIDTH-1:0]    cnt_val;
`ifdef UPDOWN_SWEEP_HOLD_EN
  logic                hold;
`endif
  logic                cnt_load;
  logic [WIDTH-1:0]    cnt_load_val;
  logic                cnt_en;
  logic                cnt_up;
  logic                busy;
  logic                done;
  logic                err;
  logic [REPEAT_W-1:0] sweeps_left;

  // Sequencer side
  modport master (
`ifdef UPDOWN_SWEEP_HOLD_EN
    input  hold,
`endif
    input  start, abort, lo, hi, repeats, step_en, cnt_val,
    output cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, err, sweeps_left
  );

  // Host / counter side
  modport slave (
`ifdef UPDOWN_SWEEP_HOLD_EN
    output hold,
`endif
    output start, abort, lo, hi, repeats, step_en, cnt_val,
    input  cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, err, sweeps_left
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep sequencer: loads lo into the counter, then sweeps lo->hi->lo `repeats` times.
// Optional feature macro: UPDOWN_SWEEP_HOLD_EN (adds a hold input that freezes the run).
module updown_sweep_ctrl #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  updown_sweep_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_hi;
  logic [REPEAT_W-1:0] r_sweeps;
  logic                r_err;

  logic                w_hold;
  logic                w_at_hi;
  logic                w_at_lo;
  logic                w_cnt_load;
  logic                w_cnt_en;
  logic                w_cnt_up;
  logic                w_done;

`ifdef UPDOWN_SWEEP_HOLD_EN
  assign w_hold = bus.hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_at_hi = (bus.cnt_val == r_hi);
  assign w_at_lo = (bus.cnt_val == r_lo);

  // abort outranks hold, hold outranks every normal transition
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lo     <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_sweeps <= {REPEAT_W{1'b0}};
      r_err    <= 1'b0;
    end else if (bus.abort) begin
      r_state <= S_IDLE;
    end else if (w_hold) begin
      r_state <= r_state;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_lo     <= bus.lo;
            r_hi     <= bus.hi;
            r_sweeps <= bus.repeats;
            r_err    <= (bus.lo > bus.hi);
            r_state  <= (bus.lo > bus.hi) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: r_state <= S_UP;
        S_UP: begin
          if (w_at_hi) r_state <= S_DOWN;
        end
        S_DOWN: begin
          if (w_at_lo) begin
            if (r_sweeps == REPEAT_W'(1)) begin
              r_state <= S_DONE;
            end else begin
              // zero means run forever, so it is never decremented
              if (r_sweeps != {REPEAT_W{1'b0}}) r_sweeps <= r_sweeps - REPEAT_W'(1);
              r_state <= S_UP;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counter controls decode straight from state and live inputs
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_up   = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: w_cnt_load = 1'b0;
      S_LOAD: w_cnt_load = 1'b1;
      S_UP:   w_cnt_en   = bus.step_en & ~w_at_hi & ~bus.abort & ~w_hold;
      S_DOWN: begin
        w_cnt_up = 1'b0;
        w_cnt_en = bus.step_en & ~w_at_lo & ~bus.abort & ~w_hold;
      end
      S_DONE:  w_done = ~r_err & ~bus.abort;
      default: w_cnt_load = 1'b0;
    endcase
  end

  assign bus.cnt_load     = w_cnt_load;
  assign bus.cnt_load_val = r_lo;
  assign bus.cnt_en       = w_cnt_en;
  assign bus.cnt_up       = w_cnt_up;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = w_done;
  assign bus.err          = r_err;
  assign bus.sweeps_left  = r_sweeps;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: a run-level model queues the expected event stream,
// a negedge monitor pops and compares every observed load/step/done/busy edge.
module tb_updown_sweep_ctrl;

  localparam int K_START = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STEP  = 2;
  localparam int K_DONE  = 3;
  localparam int K_IDLE  = 4;
  localparam int NINF    = 12;

  typedef struct {
    int kind;
    int val;
    int up;
    int sl;
  } ev_t;

  logic clk;
  logic rst;
  logic [7:0] cnt_q;
  ev_t q[$];
  int checks;
  int failures;
  int busy_cnt;
  int cyc;
  bit mon_en;
  logic prev_busy;
  logic prev_done;
`ifdef UPDOWN_SWEEP_HOLD_EN
  int hold_left;
  int hold_cnt;
  int hold_sl;
`endif

  updown_sweep_ctrl_if #(.WIDTH(8), .REPEAT_W(4)) bus ();

  updown_sweep_ctrl #(.WIDTH(8), .REPEAT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural up/down counter fed by the controller
  always @(posedge clk) begin
    if (bus.cnt_load) cnt_q <= bus.cnt_load_val;
    else if (bus.cnt_en) cnt_q <= bus.cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end
  assign bus.cnt_val = cnt_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_ev(int k, int v, int u, int s);
    ev_t e;
    e.kind = k; e.val = v; e.up = u; e.sl = s;
    q.push_back(e);
  endfunction

  // Expected event stream of a whole run, from the sweep rules
  function automatic void model_run(int lo, int hi, int rep);
    int n;
    int sl;
    if (lo > hi) begin
      push_ev(K_START, 1, 0, 0);
      push_ev(K_IDLE, 0, 0, 1);
      return;
    end
    push_ev(K_START, 0, 0, 0);
    push_ev(K_LOAD, lo, 0, 0);
    n = (rep == 0) ? NINF : rep;
    for (int k = 0; k < n; k++) begin
      sl = (rep == 0) ? 0 : rep - k;
      for (int v = lo + 1; v <= hi; v++) push_ev(K_STEP, v, 1, sl);
      for (int v = hi - 1; v >= lo; v--) push_ev(K_STEP, v, 0, sl);
    end
    if (rep != 0) push_ev(K_DONE, 0, 0, 1);
    push_ev(K_IDLE, (rep != 0) ? 1 : 0, 0, -1);
  endfunction

  task automatic take(input int kind, output ev_t e, output bit ok);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
      ok = 1'b0;
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      ok = 1'b1;
    end
  endtask

  // Monitor: every DUT-visible event is matched against the queue head
  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (mon_en) begin
      if (bus.busy && !prev_busy) begin
        take(K_START, e, ok);
        if (ok) chk("start_err", int'(bus.err), e.val);
      end
      if (bus.cnt_load) begin
        take(K_LOAD, e, ok);
        if (ok) chk("load_val", int'(bus.cnt_load_val), e.val);
      end
      if (bus.cnt_en) begin
        take(K_STEP, e, ok);
        if (ok) begin
          chk("step_val", int'(bus.cnt_val) + (bus.cnt_up ? 1 : -1), e.val);
          chk("step_dir", int'(bus.cnt_up), e.up);
          chk("step_sweeps", int'(bus.sweeps_left), e.sl);
        end
      end
      if (bus.done) begin
        take(K_DONE, e, ok);
        if (ok) chk("done_sweeps", int'(bus.sweeps_left), e.sl);
      end
      if (!bus.busy && prev_busy) begin
        take(K_IDLE, e, ok);
        if (ok) begin
          chk("idle_after_done", int'(prev_done), e.val);
          if (e.sl >= 0) chk("busy_cycles", busy_cnt, e.sl);
        end
      end
    end
    if (bus.busy) busy_cnt <= prev_busy ? busy_cnt + 1 : 1;
    prev_busy <= bus.busy;
    prev_done <= bus.done;
  end

  task automatic drive_step(input int mode);
    cyc++;
    case (mode)
      0:       bus.step_en = 1'b1;
      1:       bus.step_en = (cyc % 4 == 0);
      default: bus.step_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drain(input int target, input int mode);
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (q.size() <= target) begin
        bus.start = 1'b0;
`ifdef UPDOWN_SWEEP_HOLD_EN
        bus.hold = 1'b0;
        hold_left = 0;
`endif
        return;
      end
      drive_step(mode);
      // stray starts while busy must be ignored
      bus.start = bus.busy && ($urandom_range(0, 5) == 0);
      bus.lo = 8'($urandom_range(0, 255));
      bus.hi = 8'($urandom_range(0, 255));
      bus.repeats = 4'($urandom_range(0, 15));
`ifdef UPDOWN_SWEEP_HOLD_EN
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          bus.hold = 1'b0;
          chk("hold_cnt", int'(cnt_q), hold_cnt);
          chk("hold_sweeps", int'(bus.sweeps_left), hold_sl);
        end
      end else if (q.size() > 4 && q[0].kind == K_STEP && $urandom_range(0, 15) == 0) begin
        bus.hold = 1'b1;
        hold_left = 5;
        hold_cnt = int'(cnt_q);
        hold_sl = int'(bus.sweeps_left);
      end
`endif
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: got %0d pending events expected %0d", q.size(), target);
    q.delete();
    bus.start = 1'b0;
  endtask

  task automatic launch(input int lo, input int hi, input int rep);
    model_run(lo, hi, rep);
    bus.lo = 8'(lo);
    bus.hi = 8'(hi);
    bus.repeats = 4'(rep);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run(input int lo, input int hi, input int rep, input int mode);
    launch(lo, hi, rep);
    if (rep == 0 && lo <= hi) begin
      drain(1, mode);
      bus.step_en = 1'b0;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      bus.step_en = 1'b1;
    end
    drain(0, mode);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_cnt_load"}, int'(bus.cnt_load), 0);
    chk({tag, "_cnt_en"}, int'(bus.cnt_en), 0);
    chk({tag, "_cnt_up"}, int'(bus.cnt_up), 1);
    chk({tag, "_sweeps_left"}, int'(bus.sweeps_left), 0);
    chk({tag, "_load_val"}, int'(bus.cnt_load_val), 0);
  endtask

  initial begin
    bit found;
    checks = 0; failures = 0; cyc = 0; busy_cnt = 0;
    mon_en = 1'b0;
    cnt_q = 8'd0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.step_en = 1'b1;
    bus.lo = 8'd0; bus.hi = 8'd0; bus.repeats = 4'd0;
`ifdef UPDOWN_SWEEP_HOLD_EN
    bus.hold = 1'b0;
    hold_left = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    run(2, 5, 1, 0);
    run(0, 3, 3, 0);
    run(7, 4, 2, 0);
    chk("err_sticky", int'(bus.err), 1);
    run(1, 2, 0, 0);
    run(0, 2, 2, 1);
    run(3, 3, 2, 0);
    run(250, 255, 1, 2);
    run(0, 0, 1, 1);
    for (int r = 0; r < 12; r++)
      run($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(1, 3), $urandom_range(0, 2));
    run($urandom_range(0, 5), $urandom_range(6, 9), 0, 2);

    // reset in the middle of a down sweep
    launch(1, 6, 2);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.busy && !bus.cnt_up && cnt_q < 8'd6) found = 1'b1;
    end
    chk("reached_down", int'(found), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    mon_en = 1'b1;
    run(4, 6, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
